// File: rtl/glyph_fetch_ctrl.sv
// Text-mode tile fetch controller: shares one single-port tile RAM between
// display prefetch (strict priority) and CPU read/write requests.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | arbitrate: pending/trigger display fetch first, else CPU
// DISP_RD   | present next-tile address to the tile RAM
// DISP_LAT  | RAM read latency; capture tile code into next_value
// CPU_WR    | one-cycle write strobe (suppressed for out-of-range addr)
// CPU_RD    | present CPU address to the tile RAM
// CPU_RDLAT | RAM read latency; capture read data for the CPU
module glyph_fetch_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 60,
  parameter int HVIS = 640,
  parameter int VVIS = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [3:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [3:0]  cpu_rdata,
  output logic [12:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wdata,
  input  logic [3:0]  mem_rdata,
  output logic [3:0]  glyph_value
);

  typedef enum logic [2:0] {
    IDLE,
    DISP_RD,
    DISP_LAT,
    CPU_WR,
    CPU_RD,
    CPU_RDLAT
  } state_t;

  localparam logic [12:0] COLS_W   = 13'(COLS);
  localparam logic [12:0] NTILES   = 13'(COLS * ROWS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [10:0] HVIS_W   = 11'(HVIS);
  localparam logic [10:0] VVIS_W   = 11'(VVIS);

  state_t      state, state_nxt;
  logic [9:0]  hcount_q;
  logic        hchange, trigger, glyph_load;
  logic        pending;
  logic [6:0]  col_cur, col_nxt, row_nxt;
  logic [10:0] vnext;
  logic [12:0] tile_nxt, fetch_addr;
  logic [3:0]  next_value;
  logic        cpu_valid, rd_valid;
  logic        enter_disp;

  // row*COLS built from the constant bits of COLS, so it reduces to shift-adds
  function automatic logic [12:0] tile_addr(input logic [6:0] row, input logic [6:0] col);
    logic [12:0] acc;
    acc = '0;
    for (int i = 0; i < 13; i++) begin
      if (COLS_W[i]) acc = acc + ({6'b0, row} << i);
    end
    return acc + {6'b0, col};
  endfunction

  assign hchange    = (hcount != hcount_q) && ({1'b0, hcount} < HVIS_W);
  assign trigger    = hchange && (hcount[2:0] == 3'd4);
  assign glyph_load = hchange && (hcount[2:0] == 3'd0);
  assign cpu_valid  = (cpu_addr < NTILES);

  always_comb begin
    col_cur = hcount[9:3];
    vnext   = {1'b0, vcount} + 11'd1;
    if (col_cur < LAST_COL) begin
      col_nxt = 7'(col_cur + 7'd1);
      row_nxt = vcount[9:3];
    end else begin
      col_nxt = 7'd0;
      row_nxt = (vnext >= VVIS_W) ? 7'd0 : vnext[9:3];
    end
    tile_nxt = tile_addr(row_nxt, col_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    enter_disp = 1'b0;
    case (state)
      IDLE: begin
        if (pending || trigger) begin
          state_nxt  = DISP_RD;
          enter_disp = 1'b1;
        end else if (cpu_req && !cpu_ack) begin
          state_nxt = cpu_we ? CPU_WR : CPU_RD;
        end
      end
      DISP_RD: begin
        mem_addr  = fetch_addr;
        state_nxt = DISP_LAT;
      end
      DISP_LAT: state_nxt = IDLE;
      CPU_WR: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_valid;
        state_nxt = IDLE;
      end
      CPU_RD: begin
        mem_addr  = cpu_addr;
        state_nxt = CPU_RDLAT;
      end
      CPU_RDLAT: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= '0;
      pending     <= 1'b0;
      fetch_addr  <= '0;
      next_value  <= '0;
      glyph_value <= '0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      hcount_q <= hcount;
      if (trigger) fetch_addr <= tile_nxt;
      // a trigger that launches the fetch in the same cycle is already served
      if (enter_disp)   pending <= 1'b0;
      else if (trigger) pending <= 1'b1;
      if (state == DISP_LAT) next_value <= mem_rdata;
      if (glyph_load) glyph_value <= next_value;
      cpu_ack <= (state == CPU_WR) || (state == CPU_RDLAT);
      if (state == CPU_RD) rd_valid <= cpu_valid;
      if (state == CPU_RDLAT) cpu_rdata <= rd_valid ? mem_rdata : 4'h0;
    end
  end

endmodule

// File: tb/tb_glyph_fetch_ctrl.sv
// Directed bench for glyph_fetch_ctrl with a behavioural 1-cycle tile RAM.
module tb_glyph_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount, vcount;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [3:0]  cpu_wdata;
  logic        cpu_ack;
  logic [3:0]  cpu_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata;
  logic [3:0]  glyph_value;

  logic [3:0]  ram [0:8191] = '{default: 4'h0};

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;
  int we_cnt  = 0;
  logic [12:0] last_we_addr = '0;
  logic [3:0]  last_we_data = '0;

  glyph_fetch_ctrl dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .glyph_value(glyph_value)
  );

  always #5 clk = ~clk;

  // location 5000 lies outside the tile map; give it non-zero garbage
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr == 13'd5000) ? 4'h9 : ram[mem_addr];
  end

  always @(negedge clk) begin
    if (cpu_ack) ack_cnt++;
    if (mem_we) begin
      we_cnt++;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // call right after a negedge; lat = negedges until ack seen (0 = timeout)
  task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [3:0] wd,
                        output logic [3:0] rd, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = i;
        rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rd;
    int lat, a0, w0;

    rst = 1'b1; hcount = '0; vcount = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(3);
    chk("rst_glyph", 16'(glyph_value), 16'h0);
    chk("rst_ack", 16'(cpu_ack), 16'h0);
    chk("rst_rdata", 16'(cpu_rdata), 16'h0);
    chk("rst_we", 16'(mem_we), 16'h0);
    rst = 1'b0;
    tick(2);

    // CPU write then read of tile 85
    cpu_op(1'b1, 13'd85, 4'hA, rd, lat);
    chk("wr_lat", 16'(lat), 16'd2);
    chk("wr_addr", 16'(last_we_addr), 16'd85);
    chk("wr_data", 16'(last_we_data), 16'hA);
    cpu_op(1'b0, 13'd85, 4'h0, rd, lat);
    chk("rd_lat", 16'(lat), 16'd3);
    chk("rd_data", 16'(rd), 16'hA);

    // row 1 col 2 prefetched at hcount=12, shown from hcount=16
    cpu_op(1'b1, 13'd82, 4'h7, rd, lat);
    vcount = 10'd8;
    hcount = 10'd11; tick(2);
    hcount = 10'd12; tick(1);
    chk("fetch82_addr", 16'(mem_addr), 16'd82);
    chk("fetch82_we", 16'(mem_we), 16'h0);
    tick(3);
    for (int h = 13; h <= 15; h++) begin
      hcount = 10'(h); tick(2);
    end
    chk("glyph_pre16", 16'(glyph_value), 16'h0);
    hcount = 10'd16; tick(1);
    chk("glyph_16", 16'(glyph_value), 16'h7);

    // end-of-line wrap: last frame line wraps to row 0, line 7 to row 1
    cpu_op(1'b1, 13'd0, 4'hC, rd, lat);
    cpu_op(1'b1, 13'd80, 4'h5, rd, lat);
    vcount = 10'd479;
    hcount = 10'd635; tick(2);
    hcount = 10'd636; tick(1);
    chk("wrap0_addr", 16'(mem_addr), 16'd0);
    tick(4);
    hcount = 10'd0; tick(1);
    chk("wrap0_glyph", 16'(glyph_value), 16'hC);
    tick(1);
    vcount = 10'd7;
    hcount = 10'd635; tick(2);
    hcount = 10'd636; tick(1);
    chk("wrap80_addr", 16'(mem_addr), 16'd80);
    tick(3);
    chk("wrap80_hold", 16'(glyph_value), 16'hC);
    hcount = 10'd0; tick(1);
    chk("wrap80_glyph", 16'(glyph_value), 16'h5);
    tick(1);

    // trigger and CPU write arrive together: display goes first
    a0 = ack_cnt; w0 = we_cnt;
    hcount = 10'd4;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'd200; cpu_wdata = 4'h3;
    tick(1);
    chk("coll_disp_addr", 16'(mem_addr), 16'd1);
    chk("coll_disp_we", 16'(mem_we), 16'h0);
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = i;
        break;
      end
    end
    cpu_req = 1'b0;
    tick(2);
    chk("coll_lat", 16'(lat), 16'd5);
    chk("coll_acks", 16'(ack_cnt - a0), 16'd1);
    chk("coll_writes", 16'(we_cnt - w0), 16'd1);
    chk("coll_wr_addr", 16'(last_we_addr), 16'd200);

    // out-of-range tile addresses
    w0 = we_cnt;
    cpu_op(1'b1, 13'd4800, 4'hF, rd, lat);
    chk("oor_wr_lat", 16'(lat), 16'd2);
    cpu_op(1'b0, 13'd5000, 4'h0, rd, lat);
    chk("oor_rd_lat", 16'(lat), 16'd3);
    chk("oor_rd_data", 16'(rd), 16'h0);
    chk("oor_no_we", 16'(we_cnt - w0), 16'd0);
    cpu_op(1'b0, 13'd200, 4'h0, rd, lat);
    chk("rd200_data", 16'(rd), 16'h3);

    // reset in the middle of a CPU read with the request held
    hcount = 10'd1; tick(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd85;
    tick(1);
    rst = 1'b1;
    a0 = ack_cnt;
    tick(2);
    chk("mid_rst_ack", 16'(cpu_ack), 16'h0);
    chk("mid_rst_rdata", 16'(cpu_rdata), 16'h0);
    chk("mid_rst_glyph", 16'(glyph_value), 16'h0);
    chk("mid_rst_we", 16'(mem_we), 16'h0);
    tick(1);
    chk("mid_rst_noack", 16'(ack_cnt - a0), 16'd0);
    rst = 1'b0;
    lat = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = i;
        rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    tick(2);
    chk("post_rst_lat", 16'(lat), 16'd3);
    chk("post_rst_rdata", 16'(rd), 16'hA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
